// File: rtl/usb_tx_line_encoder.sv
// rtl/usb_tx_line_encoder.sv - USB full-speed transmit serialiser with bit stuffing, NRZI and EOP
module usb_tx_line_encoder #(
    parameter int DATA_W       = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              line_dp,
    output logic              line_dm,
    output logic              line_oe,
    output logic              busy,
    output logic              underrun
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DATA    = 3'd1;
    localparam logic [2:0] ST_STUFF   = 3'd2;
    localparam logic [2:0] ST_EOP_SE0 = 3'd3;
    localparam logic [2:0] ST_EOP_J   = 3'd4;

    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] ONE_BIT   = CNT_W'(1);
    localparam logic [3:0]       STUFF_MAX = 4'(STUFF_LEN);
    localparam logic [2:0]       SE0_LAST  = 3'(EOP_SE0_BITS - 1);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bits_left_q, bits_left_d;
    logic              shift_last_q, shift_last_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_last_q, hold_last_d;
    logic              hold_full_q, hold_full_d;
    logic              last_acc_q, last_acc_d;
    logic [3:0]        ones_q, ones_d;
    logic [2:0]        eop_cnt_q, eop_cnt_d;
    logic              eop_pend_q, eop_pend_d;
    logic              level_q, level_d;
    logic              dp_q, dp_d;
    logic              dm_q, dm_d;
    logic              oe_q, oe_d;
    logic              und_q, und_d;

    logic       xfer;
    logic       consumed;
    logic       to_eop;
    logic       cur_bit;
    logic       level_n;
    logic [3:0] ones_n;

    assign tx_ready = rst && !hold_full_q && !last_acc_q;
    assign xfer     = tx_valid && tx_ready;
    assign line_dp  = dp_q;
    assign line_dm  = dm_q;
    assign line_oe  = oe_q;
    assign busy     = (state_q != ST_IDLE);
    assign underrun = und_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bits_left_d  = bits_left_q;
        shift_last_d = shift_last_q;
        hold_d       = hold_q;
        hold_last_d  = hold_last_q;
        hold_full_d  = hold_full_q;
        last_acc_d   = last_acc_q;
        ones_d       = ones_q;
        eop_cnt_d    = eop_cnt_q;
        eop_pend_d   = eop_pend_q;
        level_d      = level_q;
        dp_d         = dp_q;
        dm_d         = dm_q;
        oe_d         = oe_q;
        und_d        = 1'b0;
        consumed     = 1'b0;
        to_eop       = 1'b0;
        cur_bit      = shift_q[0];
        level_n      = cur_bit ? level_q : ~level_q;
        ones_n       = cur_bit ? (ones_q + 4'd1) : 4'd0;

        case (state_q)
            ST_IDLE: begin
                level_d    = 1'b1;
                ones_d     = 4'd0;
                eop_cnt_d  = 3'd0;
                eop_pend_d = 1'b0;
                // The first word bypasses the holding register straight into the shifter.
                if (xfer) begin
                    shift_d      = tx_data;
                    bits_left_d  = WORD_BITS;
                    shift_last_d = tx_last;
                    consumed     = 1'b1;
                    state_d      = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_en) begin
                    level_d = level_n;
                    dp_d    = level_n;
                    dm_d    = ~level_n;
                    oe_d    = 1'b1;
                    ones_d  = ones_n;
                    if (bits_left_q == ONE_BIT) begin
                        if (shift_last_q) begin
                            to_eop = 1'b1;
                        end else if (hold_full_q) begin
                            shift_d      = hold_q;
                            shift_last_d = hold_last_q;
                            bits_left_d  = WORD_BITS;
                            hold_full_d  = 1'b0;
                        end else if (xfer) begin
                            shift_d      = tx_data;
                            shift_last_d = tx_last;
                            bits_left_d  = WORD_BITS;
                            consumed     = 1'b1;
                        end else begin
                            // Starved: close the packet and refuse further words until idle.
                            und_d      = 1'b1;
                            last_acc_d = 1'b1;
                            to_eop     = 1'b1;
                        end
                    end else begin
                        shift_d     = shift_q >> 1;
                        bits_left_d = bits_left_q - ONE_BIT;
                    end
                    if (ones_n == STUFF_MAX) begin
                        state_d    = ST_STUFF;
                        eop_pend_d = to_eop;
                    end else if (to_eop) begin
                        state_d = ST_EOP_SE0;
                    end
                end
            end
            ST_STUFF: begin
                if (bit_en) begin
                    level_d    = ~level_q;
                    dp_d       = ~level_q;
                    dm_d       = level_q;
                    oe_d       = 1'b1;
                    ones_d     = 4'd0;
                    eop_pend_d = 1'b0;
                    state_d    = eop_pend_q ? ST_EOP_SE0 : ST_DATA;
                end
            end
            ST_EOP_SE0: begin
                if (bit_en) begin
                    dp_d = 1'b0;
                    dm_d = 1'b0;
                    oe_d = 1'b1;
                    if (eop_cnt_q == SE0_LAST) begin
                        eop_cnt_d = 3'd0;
                        state_d   = ST_EOP_J;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 3'd1;
                    end
                end
            end
            ST_EOP_J: begin
                // First strobe drives J, the second releases the pads.
                if (bit_en) begin
                    if (eop_cnt_q == 3'd0) begin
                        dp_d      = 1'b1;
                        dm_d      = 1'b0;
                        oe_d      = 1'b1;
                        eop_cnt_d = 3'd1;
                    end else begin
                        oe_d       = 1'b0;
                        eop_cnt_d  = 3'd0;
                        last_acc_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (xfer && !consumed) begin
            hold_d      = tx_data;
            hold_last_d = tx_last;
            hold_full_d = 1'b1;
        end
        if (xfer && tx_last) begin
            last_acc_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bits_left_q  <= '0;
            shift_last_q <= 1'b0;
            hold_q       <= '0;
            hold_last_q  <= 1'b0;
            hold_full_q  <= 1'b0;
            last_acc_q   <= 1'b0;
            ones_q       <= 4'd0;
            eop_cnt_q    <= 3'd0;
            eop_pend_q   <= 1'b0;
            level_q      <= 1'b1;
            dp_q         <= 1'b1;
            dm_q         <= 1'b0;
            oe_q         <= 1'b0;
            und_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bits_left_q  <= bits_left_d;
            shift_last_q <= shift_last_d;
            hold_q       <= hold_d;
            hold_last_q  <= hold_last_d;
            hold_full_q  <= hold_full_d;
            last_acc_q   <= last_acc_d;
            ones_q       <= ones_d;
            eop_cnt_q    <= eop_cnt_d;
            eop_pend_q   <= eop_pend_d;
            level_q      <= level_d;
            dp_q         <= dp_d;
            dm_q         <= dm_d;
            oe_q         <= oe_d;
            und_q        <= und_d;
        end
    end
endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// tb/tb_usb_tx_line_encoder.sv - self-checking bench for usb_tx_line_encoder
module tb_usb_tx_line_encoder;
    localparam int DATA_W       = 8;
    localparam int STUFF_LEN    = 6;
    localparam int EOP_SE0_BITS = 2;
    localparam byte SYM_J   = "J";
    localparam byte SYM_K   = "K";
    localparam byte SYM_SE0 = "0";

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bit_en = 1'b0;
    logic tx_valid = 1'b0;
    logic tx_last = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic tx_ready, line_dp, line_dm, line_oe, busy, underrun;

    usb_tx_line_encoder #(
        .DATA_W(DATA_W), .STUFF_LEN(STUFF_LEN), .EOP_SE0_BITS(EOP_SE0_BITS)
    ) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_ready(tx_ready), .line_dp(line_dp), .line_dm(line_dm),
        .line_oe(line_oe), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        int                nw;
        logic [DATA_W-1:0] w0, w1, w2;
        bit                last;
        int                period;
        string             exp;
        int                exp_und;
    } vec_t;

    vec_t vecs[6];
    int n_chk = 0;
    int n_fail = 0;
    int period_v = 1;
    int phase = 0;
    bit cap_en = 1'b0;
    byte sym_q[$];
    byte exp_q[$];
    logic [DATA_W-1:0] wq[$];
    int und_cnt = 0;
    int oe_rises = 0;
    int oe_cycles = 0;
    logic oe_prev = 1'b0;
    logic mon_be;

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got '%s', expected '%s'", name, act, exp);
        end
    endtask

    function automatic string q2s(input byte q[$]);
        string s = "";
        foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
        return s;
    endfunction

    function automatic byte sym_of(input logic dp, input logic dm);
        if (dp && !dm) return SYM_J;
        if (!dp && dm) return SYM_K;
        if (!dp && !dm) return SYM_SE0;
        return "X";
    endfunction

    // Reference: walk the packet bit by bit, stuff after STUFF_LEN ones, NRZI, then EOP.
    function automatic void build_exp();
        int  ones = 0;
        bit  lvl = 1'b1;
        bit  b;
        exp_q.delete();
        foreach (wq[w]) begin
            for (int i = 0; i < DATA_W; i++) begin
                b = wq[w][i];
                if (!b) lvl = !lvl;
                exp_q.push_back(lvl ? SYM_J : SYM_K);
                ones = b ? ones + 1 : 0;
                if (ones == STUFF_LEN) begin
                    lvl = !lvl;
                    exp_q.push_back(lvl ? SYM_J : SYM_K);
                    ones = 0;
                end
            end
        end
        for (int i = 0; i < EOP_SE0_BITS; i++) exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_J);
    endfunction

    initial forever begin
        @(negedge clk);
        phase = phase + 1;
        if (phase >= period_v) phase = 0;
        bit_en = (phase == 0);
    end

    initial forever begin
        @(posedge clk);
        mon_be = bit_en;
        #1;
        if (cap_en) begin
            if (mon_be && line_oe) sym_q.push_back(sym_of(line_dp, line_dm));
            if (underrun) und_cnt++;
            if (line_oe && !oe_prev) oe_rises++;
            if (line_oe) oe_cycles++;
        end
        oe_prev = line_oe;
    end

    task automatic start_capture(input int period);
        period_v = period;
        sym_q.delete();
        und_cnt   = 0;
        oe_rises  = 0;
        oe_cycles = 0;
        cap_en    = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int budget = 0;
        while (busy && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check_int({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic run_pkt(input string name, input int period, input bit with_last);
        int budget;
        start_capture(period);
        for (int i = 0; i < wq.size(); i++) begin
            budget = 0;
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = wq[i];
            tx_last  = with_last && (i == wq.size() - 1);
            while (!tx_ready && budget < 500) begin
                @(negedge clk);
                budget++;
            end
            check_int({name, "_accept"}, int'(tx_ready), 1);
            @(posedge clk);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        wait_idle(name);
        repeat (2 * period + 2) @(negedge clk);
        cap_en = 1'b0;
    endtask

    initial begin
        int budget;
        int acc;
        int nw;
        bit lst;
        int per;

        vecs[0] = '{"sync",     1, 8'h80, 8'h00, 8'h00, 1'b1, 1, "KJKJKJKK00J", 0};
        vecs[1] = '{"all_ones", 1, 8'hFF, 8'h00, 8'h00, 1'b1, 1, "JJJJJJKKK00J", 0};
        vecs[2] = '{"stuff_end",1, 8'hFC, 8'h00, 8'h00, 1'b1, 1, "KJJJJJJJK00J", 0};
        vecs[3] = '{"b2b",      3, 8'h80, 8'h3C, 8'hA5, 1'b1, 4,
                    "KJKJKJKKJKKKKKJKKJJKJJKK00J", 0};
        vecs[4] = '{"underrun", 1, 8'h80, 8'h00, 8'h00, 1'b0, 2, "KJKJKJKK00J", 1};
        vecs[5] = '{"ones_p3",  1, 8'hFF, 8'h00, 8'h00, 1'b1, 3, "JJJJJJKKK00J", 0};

        // Reset state with strobes running.
        period_v = 1;
        repeat (4) @(posedge clk);
        #1;
        check_int("rst_dp", int'(line_dp), 1);
        check_int("rst_dm", int'(line_dm), 0);
        check_int("rst_oe", int'(line_oe), 0);
        check_int("rst_ready", int'(tx_ready), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_underrun", int'(underrun), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_int("idle_ready", int'(tx_ready), 1);

        foreach (vecs[v]) begin
            wq.delete();
            wq.push_back(vecs[v].w0);
            if (vecs[v].nw > 1) wq.push_back(vecs[v].w1);
            if (vecs[v].nw > 2) wq.push_back(vecs[v].w2);
            run_pkt(vecs[v].name, vecs[v].period, vecs[v].last);
            check_str({vecs[v].name, "_line"}, q2s(sym_q), vecs[v].exp);
            check_int({vecs[v].name, "_underrun"}, und_cnt, vecs[v].exp_und);
            check_int({vecs[v].name, "_oe_rises"}, oe_rises, 1);
            check_int({vecs[v].name, "_oe_cycles"}, oe_cycles, vecs[v].exp.len() * vecs[v].period);
            check_int({vecs[v].name, "_ready_after"}, int'(tx_ready), 1);
        end

        // Underrun: words offered during the EOP must be refused.
        start_capture(2);
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'h80; tx_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        budget = 0;
        while (und_cnt == 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check_int("ur_seen", und_cnt, 1);
        tx_valid = 1'b1; tx_data = 8'h55;
        acc = 0; budget = 0;
        while (busy && budget < 500) begin
            if (tx_ready) acc++;
            @(negedge clk);
            budget++;
        end
        tx_valid = 1'b0;
        check_int("ur_refused", acc, 0);
        check_int("ur_idle", int'(busy), 0);
        repeat (4) @(negedge clk);
        cap_en = 1'b0;
        check_str("ur_line", q2s(sym_q), "KJKJKJKK00J");
        check_int("ur_pulses", und_cnt, 1);

        // Reset during the third bit of 0x00.
        start_capture(4);
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0; tx_last = 1'b0;
        budget = 0;
        while (sym_q.size() < 3 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check_int("mid_bits", sym_q.size(), 3);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_int("mid_dp", int'(line_dp), 1);
        check_int("mid_dm", int'(line_dm), 0);
        check_int("mid_oe", int'(line_oe), 0);
        check_int("mid_ready", int'(tx_ready), 0);
        check_int("mid_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cap_en = 1'b0;
        check_str("mid_partial", q2s(sym_q), "KJK");
        wq.delete();
        wq.push_back(8'h80);
        run_pkt("post_rst", 1, 1'b1);
        check_str("post_rst_line", q2s(sym_q), "KJKJKJKK00J");

        // Randomised packets against the reference model.
        for (int it = 0; it < 24; it++) begin
            nw  = $urandom_range(1, 3);
            lst = ($urandom_range(0, 3) != 0);
            per = $urandom_range(1, 5);
            wq.delete();
            for (int i = 0; i < nw; i++) wq.push_back(DATA_W'($urandom | $urandom));
            build_exp();
            run_pkt($sformatf("rnd%0d", it), per, lst);
            check_str($sformatf("rnd%0d_line", it), q2s(sym_q), q2s(exp_q));
            check_int($sformatf("rnd%0d_underrun", it), und_cnt, lst ? 0 : 1);
            check_int($sformatf("rnd%0d_oe_cycles", it), oe_cycles, exp_q.size() * per);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
